// File: rtl/tri_eth_cmd_sched.sv
// -----------------------------------------------------------------------------
// tri_eth_cmd_sched
//
// This block drives the LocalBus command input of one tri-mode Ethernet port.
// After reset it waits START_DELAY cycles and then writes three fixed MAC boot
// configuration commands: RX enable, TX enable and speed. Once those are done,
// it shares the command input between two host requesters using round-robin
// arbitration. It honours almost-full backpressure and forces GAP_CYCLES idle
// cycles after every issued command.
//
// Handshake: a requester's command is taken in any cycle where its valid and
// ready are both high. Ready is combinational and never waits for valid. At
// most one ready is high in a cycle. The accepted command appears on o_cmd
// with o_cmd_wr high in the following cycle.
//
// Ports:
//   i_sys_clk, i_sys_rst_n        clock, asynchronous active-low reset
//   i_req0_valid/cmd, o_req0_ready  requester 0 command handshake
//   i_req1_valid/cmd, o_req1_ready  requester 1 command handshake
//   o_cmd_wr, o_cmd               registered LocalBus command write
//   i_allmostfull                 LocalBus almost-full (blocks issue)
//   i_reinit                      pulse in RUN restarts the boot sequence
//   o_init_done                   boot sequence complete
//   o_grant_id                    source of the last issued host command
// -----------------------------------------------------------------------------
module tri_eth_cmd_sched #(
    parameter int          START_DELAY   = 16,
    parameter int          GAP_CYCLES    = 2,
    parameter logic [23:0] MAC_BASE_ADDR = 24'h000100,
    parameter logic [1:0]  INIT_SPEED    = 2'b10
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst_n,
    input  logic        i_req0_valid,
    input  logic [63:0] i_req0_cmd,
    output logic        o_req0_ready,
    input  logic        i_req1_valid,
    input  logic [63:0] i_req1_cmd,
    output logic        o_req1_ready,
    output logic        o_cmd_wr,
    output logic [63:0] o_cmd,
    input  logic        i_allmostfull,
    input  logic        i_reinit,
    output logic        o_init_done,
    output logic        o_grant_id
);

    localparam int DW = (START_DELAY < 2) ? 1 : $clog2(START_DELAY + 1);
    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] delay_cnt;
    logic [GW-1:0] gap_cnt;
    logic [1:0]    init_idx;
    logic          last_grant;

    logic          issue_ok;
    logic          grant;
    logic          host_en;
    logic          init_issue;
    logic          host_accept;
    logic [63:0]   init_cmd;

    assign issue_ok = (gap_cnt == '0) && !i_allmostfull;

    // State register
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state <= ST_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. WAIT leaves when the counter is about to reach zero,
    // so the first init command can issue exactly START_DELAY cycles after
    // the counter was loaded.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT: if (delay_cnt <= DW'(1)) state_nxt = ST_INIT;
            ST_INIT: if (init_issue && (init_idx == 2'd2)) state_nxt = ST_RUN;
            ST_RUN:  if (i_reinit) state_nxt = ST_WAIT;
            default: state_nxt = ST_WAIT;
        endcase
    end

    // Output/decision logic
    always_comb begin
        // Single valid requester wins; on a tie or when nobody is valid, the
        // requester not granted last time is offered the slot.
        if (i_req0_valid && !i_req1_valid) begin
            grant = 1'b0;
        end else if (i_req1_valid && !i_req0_valid) begin
            grant = 1'b1;
        end else begin
            grant = ~last_grant;
        end

        init_issue   = (state == ST_INIT) && issue_ok;
        // A reinit in RUN takes precedence over any request in the same cycle.
        host_en      = (state == ST_RUN) && issue_ok && !i_reinit;
        o_req0_ready = host_en && !grant;
        o_req1_ready = host_en && grant;
        host_accept  = (o_req0_ready && i_req0_valid) || (o_req1_ready && i_req1_valid);

        case (init_idx)
            2'd0:    init_cmd = {8'h01, MAC_BASE_ADDR,          32'h1000_0000};
            2'd1:    init_cmd = {8'h01, MAC_BASE_ADDR + 24'd4,  32'h1000_0000};
            default: init_cmd = {8'h01, MAC_BASE_ADDR + 24'd8,  INIT_SPEED, 30'b0};
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            delay_cnt   <= DW'(START_DELAY);
            gap_cnt     <= '0;
            init_idx    <= 2'd0;
            last_grant  <= 1'b1;
            o_cmd_wr    <= 1'b0;
            o_cmd       <= 64'h0;
            o_init_done <= 1'b0;
            o_grant_id  <= 1'b0;
        end else begin
            o_cmd_wr <= init_issue || host_accept;

            if (init_issue || host_accept) begin
                gap_cnt <= GW'(GAP_CYCLES);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end

            case (state)
                ST_WAIT: begin
                    if (delay_cnt != '0) begin
                        delay_cnt <= delay_cnt - DW'(1);
                    end
                end
                ST_INIT: begin
                    if (init_issue) begin
                        o_cmd <= init_cmd;
                        if (init_idx == 2'd2) begin
                            init_idx    <= 2'd0;
                            o_init_done <= 1'b1;
                        end else begin
                            init_idx <= init_idx + 2'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_reinit) begin
                        delay_cnt   <= DW'(START_DELAY);
                        init_idx    <= 2'd0;
                        o_init_done <= 1'b0;
                    end else if (host_accept) begin
                        o_cmd      <= grant ? i_req1_cmd : i_req0_cmd;
                        last_grant <= grant;
                        o_grant_id <= grant;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_eth_cmd_sched.sv
module tb_tri_eth_cmd_sched;

    localparam int START_DELAY = 16;
    localparam int GAP_CYCLES  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid;
    logic [63:0] req0_cmd;
    logic        req0_ready;
    logic        req1_valid;
    logic [63:0] req1_cmd;
    logic        req1_ready;
    logic        cmd_wr;
    logic [63:0] cmd;
    logic        allmostfull;
    logic        reinit;
    logic        init_done;
    logic        grant_id;

    always #5 clk = ~clk;

    tri_eth_cmd_sched #(
        .START_DELAY   (START_DELAY),
        .GAP_CYCLES    (GAP_CYCLES),
        .MAC_BASE_ADDR (24'h000100),
        .INIT_SPEED    (2'b10)
    ) dut (
        .i_sys_clk     (clk),
        .i_sys_rst_n   (rst_n),
        .i_req0_valid  (req0_valid),
        .i_req0_cmd    (req0_cmd),
        .o_req0_ready  (req0_ready),
        .i_req1_valid  (req1_valid),
        .i_req1_cmd    (req1_cmd),
        .o_req1_ready  (req1_ready),
        .o_cmd_wr      (cmd_wr),
        .o_cmd         (cmd),
        .i_allmostfull (allmostfull),
        .i_reinit      (reinit),
        .o_init_done   (init_done),
        .o_grant_id    (grant_id)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: time is counted in cycles since reset release.
    // init_start is the first cycle an init command may go out, next_ok the
    // first cycle after the gap, init_q the boot commands still owed.
    int          cyc;
    int          init_start;
    int          next_ok;
    logic        last;
    logic [63:0] init_q[$];
    logic        exp_wr;
    logic [63:0] exp_cmd;
    logic        exp_done;
    logic        exp_gid;
    logic        exp_rdy0;
    logic        exp_rdy1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic load_init_q();
        init_q = {64'h01000100_10000000, 64'h01000104_10000000, 64'h01000108_80000000};
    endtask

    task automatic model_reset();
        cyc        = 0;
        init_start = START_DELAY;
        next_ok    = 0;
        last       = 1'b1;
        exp_wr     = 1'b0;
        exp_cmd    = 64'h0;
        exp_done   = 1'b0;
        exp_gid    = 1'b0;
        load_init_q();
    endtask

    task automatic drive(input logic v0, input logic v1, input logic af, input logic ri);
        req0_valid  = v0;
        req1_valid  = v1;
        req0_cmd    = {$urandom, $urandom};
        req1_cmd    = {$urandom, $urandom};
        allmostfull = af;
        reinit      = ri;
    endtask

    // One clock cycle: predict, check mid-cycle, advance the model.
    task automatic run_cycle();
        logic        ok;
        logic        iss;
        logic        g;
        logic [63:0] c;
        logic        nd;
        logic        ng;
        ok       = (cyc >= next_ok) && !allmostfull;
        exp_rdy0 = 1'b0;
        exp_rdy1 = 1'b0;
        iss      = 1'b0;
        c        = exp_cmd;
        nd       = exp_done;
        ng       = exp_gid;
        if (cyc < init_start) begin
            iss = 1'b0;
        end else if (init_q.size() != 0) begin
            if (ok) begin
                c   = init_q.pop_front();
                iss = 1'b1;
                if (init_q.size() == 0) nd = 1'b1;
            end
        end else if (reinit) begin
            init_start = cyc + 1 + START_DELAY;
            load_init_q();
            nd = 1'b0;
        end else if (ok) begin
            if (req0_valid != req1_valid) g = req1_valid;
            else g = ~last;
            exp_rdy0 = ~g;
            exp_rdy1 = g;
            if (g ? req1_valid : req0_valid) begin
                iss  = 1'b1;
                c    = g ? req1_cmd : req0_cmd;
                last = g;
                ng   = g;
            end
        end
        @(negedge clk);
        chk("cmd_wr", 64'(cmd_wr), 64'(exp_wr));
        chk("cmd", cmd, exp_cmd);
        chk("init_done", 64'(init_done), 64'(exp_done));
        chk("grant_id", 64'(grant_id), 64'(exp_gid));
        chk("req0_ready", 64'(req0_ready), 64'(exp_rdy0));
        chk("req1_ready", 64'(req1_ready), 64'(exp_rdy1));
        chk("one_hot_ready", 64'(req0_ready & req1_ready), 64'h0);
        @(posedge clk);
        #1;
        if (iss) next_ok = cyc + 1 + GAP_CYCLES;
        exp_wr   = iss;
        exp_cmd  = c;
        exp_done = nd;
        exp_gid  = ng;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_wr"}, 64'(cmd_wr), 64'h0);
        chk({tag, "_cmd"}, cmd, 64'h0);
        chk({tag, "_rdy0"}, 64'(req0_ready), 64'h0);
        chk({tag, "_rdy1"}, 64'(req1_ready), 64'h0);
        chk({tag, "_done"}, 64'(init_done), 64'h0);
        chk({tag, "_gid"}, 64'(grant_id), 64'h0);
    endtask

    initial begin
        logic found;
        // Clock/reset
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        model_reset();

        // Boot sequence with no backpressure
        repeat (30) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            run_cycle();
        end

        // Reinit against a ready-eligible req0: no accept, boot repeats
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (cyc >= next_ok) found = 1'b1;
            else begin
                drive(1'b0, 1'b0, 1'b0, 1'b0);
                run_cycle();
            end
        end
        chk("reach_eligible", 64'(found), 64'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        run_cycle();
        // Backpressure held through the whole init window, then released
        repeat (25) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            run_cycle();
        end
        repeat (15) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            run_cycle();
        end

        // Only req1 valid
        repeat (30) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            run_cycle();
        end
        // Both valid: alternation
        repeat (30) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            run_cycle();
        end

        // Random traffic
        repeat (800) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 99) == 0));
            run_cycle();
        end

        // Asynchronous reset in a gap during RUN
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (exp_wr && init_q.size() == 0 && cyc >= init_start) found = 1'b1;
            else begin
                drive(1'b1, 1'b0, 1'b0, 1'b0);
                run_cycle();
            end
        end
        chk("reach_run_gap", 64'(found), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (40) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            run_cycle();
        end
        repeat (150) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 79) == 0));
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
